// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection scheduler: tick-timed green/yellow/all-red sequencing
// with sensor-driven green exit and a latched pedestrian WALK phase.
module traffic_phase_scheduler #(
  parameter int TICK_DIV  = 4,
  parameter int GREEN_MIN = 6,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW    = 2,
  parameter int ALLRED    = 1,
  parameter int WALK      = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sa_i,
  input  logic       sb_i,
  input  logic       ped_req_i,
  output logic       ra_o,
  output logic       ya_o,
  output logic       ga_o,
  output logic       rb_o,
  output logic       yb_o,
  output logic       gb_o,
  output logic       walk_o,
  output logic       ped_ack_o,
  output logic [2:0] phase_o
);

  localparam logic [2:0] S_A_GREEN   = 3'd0;
  localparam logic [2:0] S_A_YELLOW  = 3'd1;
  localparam logic [2:0] S_ALLRED_AB = 3'd2;
  localparam logic [2:0] S_B_GREEN   = 3'd3;
  localparam logic [2:0] S_B_YELLOW  = 3'd4;
  localparam logic [2:0] S_ALLRED_BA = 3'd5;
  localparam logic [2:0] S_WALK      = 3'd6;

  localparam logic [7:0] TICK_LAST   = 8'(TICK_DIV - 1);
  localparam logic [7:0] GMIN_LAST   = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_LAST   = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_LAST    = 8'(YELLOW - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] dwell_q, dwell_d;
  logic       pedPending_q, pedPending_d;
  logic       nextB_q, nextB_d;
  logic       pedAck_q, pedAck_d;
  logic       tick, minOk, stateChange;

  assign tick  = (presc_q == TICK_LAST);
  assign minOk = tick && (dwell_q >= GMIN_LAST);

  always_comb begin
    state_d = state_q;
    nextB_d = nextB_q;
    case (state_q)
      S_A_GREEN:   if (minOk && (sb_i || pedPending_q)) state_d = S_A_YELLOW;
      S_A_YELLOW:  if (tick && dwell_q == YEL_LAST) state_d = S_ALLRED_AB;
      S_ALLRED_AB: begin
        if (tick && dwell_q == ALLRED_LAST) begin
          if (pedPending_q) begin
            state_d = S_WALK;
            nextB_d = sb_i;
          end else begin
            state_d = S_B_GREEN;
          end
        end
      end
      S_B_GREEN: begin
        if ((minOk && (sa_i || !sb_i || pedPending_q)) || (tick && dwell_q == GMAX_LAST))
          state_d = S_B_YELLOW;
      end
      S_B_YELLOW:  if (tick && dwell_q == YEL_LAST) state_d = S_ALLRED_BA;
      S_ALLRED_BA: begin
        if (tick && dwell_q == ALLRED_LAST) begin
          if (pedPending_q) begin
            state_d = S_WALK;
            nextB_d = 1'b0;
          end else begin
            state_d = S_A_GREEN;
          end
        end
      end
      S_WALK:      if (tick && dwell_q == WALK_LAST) state_d = nextB_q ? S_B_GREEN : S_A_GREEN;
      default:     state_d = S_A_GREEN;
    endcase
  end

  // Timers restart on every state change; entering WALK beats a same-edge request.
  always_comb begin
    stateChange  = (state_d != state_q);
    presc_d      = (stateChange || tick) ? 8'd0 : presc_q + 8'd1;
    dwell_d      = stateChange ? 8'd0 : (tick ? dwell_q + 8'd1 : dwell_q);
    pedPending_d = (state_d == S_WALK && state_q != S_WALK) ? 1'b0
                 : (pedPending_q || (ped_req_i && state_q != S_WALK));
    pedAck_d     = !pedPending_q && pedPending_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_A_GREEN;
      presc_q      <= 8'd0;
      dwell_q      <= 8'd0;
      pedPending_q <= 1'b0;
      nextB_q      <= 1'b0;
      pedAck_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      dwell_q      <= dwell_d;
      pedPending_q <= pedPending_d;
      nextB_q      <= nextB_d;
      pedAck_q     <= pedAck_d;
    end
  end

  // Any non-green/yellow code, including illegal 7, shows red on that road.
  assign ga_o      = (state_q == S_A_GREEN);
  assign ya_o      = (state_q == S_A_YELLOW);
  assign ra_o      = !(ga_o || ya_o);
  assign gb_o      = (state_q == S_B_GREEN);
  assign yb_o      = (state_q == S_B_YELLOW);
  assign rb_o      = !(gb_o || yb_o);
  assign walk_o    = (state_q == S_WALK);
  assign ped_ack_o = pedAck_q;
  assign phase_o   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: an elapsed-cycle reference model queues expected outputs each
// edge, a negedge monitor compares them, and directed checks pin known cycle timings.
module tb_traffic_phase_scheduler;

  localparam int TD = 4, GMIN = 6, GMAX = 12, YEL = 2, AR = 1, WK = 4;
  localparam int AG = 0, AY = 1, AAB = 2, BG = 3, BY = 4, ABA = 5, WS = 6;

  logic       clk = 1'b0, rst = 1'b1, sa = 1'b0, sb = 1'b0, pedReq = 1'b0;
  logic       ra, ya, ga, rb, yb, gb, walk, pedAck;
  logic [2:0] phase;

  int assertCount = 0;
  int failCount   = 0;

  logic [10:0] expQ[$];
  int  mState = AG, mT = 0;
  bit  mPend = 0, mNextB = 0, mAck = 0;

  int    chkCyc[$], chkSig[$], chkVal[$];
  string chkName[$];

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .clk_i(clk), .rst_i(rst), .sa_i(sa), .sb_i(sb), .ped_req_i(pedReq),
    .ra_o(ra), .ya_o(ya), .ga_o(ga), .rb_o(rb), .yb_o(yb), .gb_o(gb),
    .walk_o(walk), .ped_ack_o(pedAck), .phase_o(phase)
  );

  // Lamp table {Ra,Ya,Ga,Rb,Yb,Gb,walk} per phase.
  function automatic logic [10:0] expectedOut(int st, bit ack);
    logic [6:0] lamps;
    case (st)
      AG:      lamps = 7'b0011000;
      AY:      lamps = 7'b0101000;
      AAB:     lamps = 7'b1001000;
      BG:      lamps = 7'b1000010;
      BY:      lamps = 7'b1000100;
      ABA:     lamps = 7'b1001000;
      default: lamps = 7'b1001001;
    endcase
    return {3'(st), lamps, ack};
  endfunction

  task automatic modelStep(input bit r, input bit a, input bit b, input bit p);
    int nst, ticks;
    bit tickEdge, minOk, newPend;
    if (r) begin
      mState = AG; mT = 0; mPend = 0; mNextB = 0; mAck = 0;
    end else begin
      tickEdge = (mT % TD) == TD - 1;
      ticks    = (mT / TD) % 256;
      minOk    = tickEdge && ticks >= GMIN - 1;
      nst      = mState;
      case (mState)
        AG:  if (minOk && (b || mPend)) nst = AY;
        AY:  if (tickEdge && ticks == YEL - 1) nst = AAB;
        AAB: if (tickEdge && ticks == AR - 1) begin
               if (mPend) begin nst = WS; mNextB = b; end else nst = BG;
             end
        BG:  if ((minOk && (a || !b || mPend)) || (tickEdge && ticks == GMAX - 1)) nst = BY;
        BY:  if (tickEdge && ticks == YEL - 1) nst = ABA;
        ABA: if (tickEdge && ticks == AR - 1) begin
               if (mPend) begin nst = WS; mNextB = 0; end else nst = AG;
             end
        default: if (tickEdge && ticks == WK - 1) nst = mNextB ? BG : AG;
      endcase
      newPend = (nst == WS && mState != WS) ? 1'b0 : (mPend || (p && mState != WS));
      mAck    = !mPend && newPend;
      mPend   = newPend;
      mT      = (nst != mState) ? 0 : mT + 1;
      mState  = nst;
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep(rst, sa, sb, pedReq);
    expQ.push_back(expectedOut(mState, mAck));
  end

  initial forever begin
    logic [10:0] exp, act;
    @(negedge clk);
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard: DUT output with no expected entry queued");
    end else begin
      exp = expQ.pop_front();
      act = {phase, ra, ya, ga, rb, yb, gb, walk, pedAck};
      if (act !== exp) begin
        failCount++;
        $display("[TB] FAIL scoreboard @%0t: got phase=%0d lamps=%b ack=%b, expected phase=%0d lamps=%b ack=%b",
                 $time, act[10:8], act[7:1], act[0], exp[10:8], exp[7:1], exp[0]);
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit a, input bit b, input bit p);
    rst = r; sa = a; sb = b; pedReq = p;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int sigValue(int sel);
    case (sel)
      0:       return int'(phase);
      1:       return int'(pedAck);
      2:       return int'(walk);
      3:       return int'(ga);
      default: return int'(rb);
    endcase
  endfunction

  task automatic addCheck(input int c, input int sel, input int v, input string name);
    chkCyc.push_back(c); chkSig.push_back(sel); chkVal.push_back(v);
    chkName.push_back($sformatf("%s@%0d", name, c));
  endtask

  task automatic resetDut();
    applyStimulus(1, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  // Cycle 0 is the first cycle after reset; inputs set in cycle c are sampled at its closing edge.
  task automatic runScenario(input int n, input bit a, input bit b, input int p1From, input int p1To,
                             input int p2From, input int p2To, input int rstAt, input bit idle);
    for (int c = 0; c < n; c++) begin
      applyStimulus(c == rstAt, a, b, (c >= p1From && c <= p1To) || (c >= p2From && c <= p2To));
      @(negedge clk);
      if (idle) checkOutput($sformatf("idleLamps@%0d", c), int'({ga, rb, phase, pedAck}), 6'b110000);
      for (int i = 0; i < chkCyc.size(); i++)
        if (chkCyc[i] == c) checkOutput(chkName[i], sigValue(chkSig[i]), chkVal[i]);
      @(posedge clk); #1;
    end
    chkCyc.delete(); chkSig.delete(); chkVal.delete(); chkName.delete();
  endtask

  initial begin
    bit a, b;

    resetDut();
    runScenario(300, 0, 0, -1, -1, -1, -1, -1, 1);

    resetDut();
    addCheck(23, 0, AG, "phase"); addCheck(24, 0, AY, "phase"); addCheck(31, 0, AY, "phase");
    addCheck(32, 0, AAB, "phase"); addCheck(35, 0, AAB, "phase"); addCheck(36, 0, BG, "phase");
    addCheck(83, 0, BG, "phase"); addCheck(84, 0, BY, "phase"); addCheck(91, 0, BY, "phase");
    addCheck(92, 0, ABA, "phase"); addCheck(95, 0, ABA, "phase"); addCheck(96, 0, AG, "phase");
    runScenario(100, 0, 1, -1, -1, -1, -1, -1, 0);

    resetDut();
    addCheck(59, 0, BG, "phaseSaSb"); addCheck(60, 0, BY, "phaseSaSb"); addCheck(67, 0, BY, "phaseSaSb");
    addCheck(68, 0, ABA, "phaseSaSb"); addCheck(71, 0, ABA, "phaseSaSb"); addCheck(72, 0, AG, "phaseSaSb");
    runScenario(80, 1, 1, -1, -1, -1, -1, -1, 0);

    resetDut();
    addCheck(5, 1, 0, "pedAck"); addCheck(6, 1, 1, "pedAck"); addCheck(7, 1, 0, "pedAck");
    addCheck(23, 0, AG, "pedPhase"); addCheck(24, 0, AY, "pedPhase"); addCheck(32, 0, AAB, "pedPhase");
    addCheck(35, 0, AAB, "pedPhase"); addCheck(36, 0, WS, "pedPhase"); addCheck(36, 2, 1, "walk");
    addCheck(36, 3, 0, "ga"); addCheck(36, 4, 1, "rb"); addCheck(51, 0, WS, "pedPhase");
    addCheck(52, 0, AG, "pedPhase"); addCheck(52, 2, 0, "walk"); addCheck(130, 0, AG, "pedPhase");
    runScenario(140, 0, 0, 5, 5, -1, -1, -1, 0);

    resetDut();
    addCheck(6, 1, 1, "heldAck"); addCheck(37, 1, 0, "heldAck"); addCheck(45, 1, 0, "heldAck");
    addCheck(52, 1, 0, "heldAck"); addCheck(52, 0, AG, "heldPhase"); addCheck(76, 0, AG, "heldPhase");
    addCheck(90, 0, AG, "heldPhase");
    runScenario(100, 0, 0, 5, 5, 36, 51, -1, 0);

    resetDut();
    addCheck(85, 0, BY, "rstPhase"); addCheck(86, 1, 1, "rstAck"); addCheck(87, 0, AG, "rstPhase");
    addCheck(87, 3, 1, "rstGa"); addCheck(87, 4, 1, "rstRb"); addCheck(87, 1, 0, "rstAck");
    addCheck(110, 0, AG, "rstPhase"); addCheck(111, 0, AY, "rstPhase"); addCheck(119, 0, AAB, "rstPhase");
    addCheck(123, 0, BG, "rstPhase");
    runScenario(130, 0, 1, 85, 85, -1, -1, 86, 0);

    // Sensors change slowly so both sensor-driven and forced green exits occur.
    a = 0; b = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) b = 1'($urandom_range(0, 1));
      applyStimulus($urandom_range(0, 499) == 0, a, b, $urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end

    applyStimulus(0, 0, 0, 0);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Tick-timed two-road intersection scheduler with vehicle sensors and a pedestrian WALK phase. Sequences lights for road A (main) and road B (side). Adds timed yellow, all-red clearance, minimum and maximum green, and a latched pedestrian request. Sits between the sensor/button inputs and the lamp drivers and replaces free-running per-cycle sequencing with parameterised dwell times.

## Interface
- TICK_DIV, 4: clk cycles per timing tick; valid range 1..255.
- GREEN_MIN, 6: minimum green, in ticks, for either road; valid range 1..255.
- GREEN_MAX, 12: forced end of B green, in ticks; must be ≥ GREEN_MIN and ≤ 255.
- YELLOW, 2: yellow duration, in ticks.
- ALLRED, 1: all-red clearance, in ticks.
- WALK, 4: pedestrian walk duration, in ticks.
- clk  in  1  the single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Sa  in  1  vehicle present on road A.
- Sb  in  1  vehicle present on road B.
- ped_req  in  1  pedestrian button, sampled every cycle.
- Ra, Ya, Ga  out  1 each  road A lamps.
- Rb, Yb, Gb  out  1 each  road B lamps.
- walk  out  1  pedestrian WALK lamp.
- ped_ack  out  1  one-cycle pulse when a request is latched.
- phase  out  3  current state encoding.

## Operation
- States and phase codes:
  - A_GREEN=0: Ga, Rb.
  - A_YELLOW=1: Ya, Rb.
  - ALLRED_AB=2: Ra, Rb.
  - B_GREEN=3: Ra, Gb.
  - B_YELLOW=4: Ra, Yb.
  - ALLRED_BA=5: Ra, Rb.
  - WALK=6: Ra, Rb, walk.
  - Code 7 is illegal and goes to A_GREEN on the next edge.
- Outputs decode from the state register only. There is no combinational path from inputs to outputs.
- Invariants:
  - Exactly one of R/Y/G is high per road.
  - Ga|Ya and Gb|Yb are never both high.
  - walk=1 only in WALK.
- Prescaler counts 0..TICK_DIV-1; tick=1 when prescaler==TICK_DIV-1.
- dwell is 8 bits and increments on tick.
- On every state change, prescaler and dwell both clear to 0.
- "expires(N)" = tick && dwell==N-1.
- Transitions, evaluated on each edge:
  - A_GREEN → A_YELLOW when dwell≥GREEN_MIN-1 && tick && (Sb | ped_pending). Otherwise stay; A has no maximum.
  - A_YELLOW → ALLRED_AB at expires(YELLOW).
  - ALLRED_AB at expires(ALLRED):
    - → WALK if ped_pending, with next_b=Sb.
    - else → B_GREEN.
  - B_GREEN → B_YELLOW when either:
    - dwell≥GREEN_MIN-1 && tick && (Sa | !Sb | ped_pending), or
    - expires(GREEN_MAX).
  - B_YELLOW → ALLRED_BA at expires(YELLOW).
  - ALLRED_BA at expires(ALLRED):
    - → WALK if ped_pending, with next_b=0.
    - else → A_GREEN.
  - WALK at expires(WALK) → B_GREEN if next_b, else A_GREEN.
- Pedestrian latch:
  - ped_pending sets on any edge where ped_req=1 and state≠WALK.
  - ped_pending clears on entry to WALK.
  - ped_req during WALK is ignored.
- ped_ack is high for the one cycle after the edge where ped_pending goes 0→1. Requests while already pending do not pulse ped_ack.
- Set and clear on the same edge (entering WALK while ped_req=1): clear wins, because state≠WALK refers to the current state.

## Timing
- Reset values: state=A_GREEN, Ga=1, Rb=1, all other lamps 0, walk=0, ped_ack=0, phase=0. ped_pending, next_b, prescaler and dwell are all 0.
- rst takes priority over all other activity in any state, including mid-WALK.
- Fixed-duration states last exactly N×TICK_DIV cycles.
- Green states last at least GREEN_MIN×TICK_DIV cycles.
- B green lasts at most GREEN_MAX×TICK_DIV cycles.
- Cycle 0 = first edge with rst=0. With defaults, A_GREEN exits no earlier than the edge ending cycle 23.
- Sensor inputs are sampled only on tick edges for green exit.

## Test plan
- Reset, Sa=Sb=ped_req=0 for 300 cycles → Ga=1 and Rb=1 throughout; phase=0; ped_ack never high.
- Sb=1, Sa=0 from cycle 0:
  - A_GREEN cycles 0–23, A_YELLOW 24–31, ALLRED_AB 32–35.
  - B_GREEN 36–83 (forced by GREEN_MAX), B_YELLOW 84–91, ALLRED_BA 92–95.
  - A_GREEN from cycle 96.
- Sb=1, Sa=1 → B_GREEN 36–59, B_YELLOW 60–67, ALLRED_BA 68–71, A_GREEN from 72.
- Sb=0, ped_req=1 for cycle 5 only:
  - ped_ack=1 in cycle 6 only.
  - A_YELLOW 24–31, ALLRED_AB 32–35, WALK 36–51 (walk=1, Ra=Rb=1).
  - A_GREEN from 52; ped_pending cleared.
- ped_req held high during WALK → no ped_ack; no second WALK after the return to A_GREEN.
- rst=1 for one cycle mid B_YELLOW → next cycle Ga=1, Rb=1, phase=0, ped_pending=0. The full A-side timing then restarts from cycle 0.
